// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam logic CPU = 1'b0;
    localparam logic DMA = 1'b1;

    localparam int          PER_SEL_BIT_DEF = 30;
    localparam logic [31:0] BUS_ADDR_RST    = 32'h0000_0000;
    localparam logic [31:0] BUS_WDATA_RST   = 32'h0000_0000;

    function automatic logic [1:0] id2onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select: lone requester wins, ties go to the CPU under fixed
// priority, otherwise to the master that was not served last.
module rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fixed_prio_i,
    output logic [1:0] win_o
);

    always_comb begin
        win_o = 2'b00;
        case (req_i)
            2'b01:   win_o = 2'b01;
            2'b10:   win_o = 2'b10;
            2'b11:   win_o = (fixed_prio_i || (last_i == DMA)) ? 2'b01 : 2'b10;
            default: win_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the DataMem/Peripheral bus between the CPU MEM-stage port and a DMA
// requester; each access runs IDLE -> GRANT (strobe) -> ACK (ack pulse).
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter bit CPU_FIXED_PRIO = 1'b0,
    parameter int PER_SEL_BIT    = PER_SEL_BIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        per_rd,
    output logic        per_wr,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] per_rdata,
    output logic [1:0]  grant
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic [1:0]  win;
    logic        per_sel;
    logic [31:0] rd_sel;

    rr_pick2 u_pick (
        .req_i        ({dma_req, cpu_req}),
        .last_i       (last_q),
        .fixed_prio_i (CPU_FIXED_PRIO),
        .win_o        (win)
    );

    assign per_sel = bus_addr_q[PER_SEL_BIT];
    assign rd_sel  = per_sel ? per_rdata : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= CPU;
            last_q      <= DMA;
            wr_q        <= 1'b0;
            bus_addr_q  <= BUS_ADDR_RST;
            bus_wdata_q <= BUS_WDATA_RST;
            cpu_rdata_q <= 32'h0;
            dma_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wr_d        = wr_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                // Latch the winner's request so the master may change its inputs afterwards
                if (|win) begin
                    state_d     = GRANT;
                    owner_d     = win[1];
                    wr_d        = win[1] ? dma_wr    : cpu_wr;
                    bus_addr_d  = win[1] ? dma_addr  : cpu_addr;
                    bus_wdata_d = win[1] ? dma_wdata : cpu_wdata;
                end
            end
            GRANT: begin
                state_d = ACK;
                if (!wr_q) begin
                    if (owner_q == DMA) dma_rdata_d = rd_sel;
                    else                cpu_rdata_d = rd_sel;
                end
            end
            ACK: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_rd  = (state_q == GRANT) && !wr_q && !per_sel;
        mem_wr  = (state_q == GRANT) &&  wr_q && !per_sel;
        per_rd  = (state_q == GRANT) && !wr_q &&  per_sel;
        per_wr  = (state_q == GRANT) &&  wr_q &&  per_sel;
        cpu_ack = (state_q == ACK) && (owner_q == CPU);
        dma_ack = (state_q == ACK) && (owner_q == DMA);
        grant   = (state_q == IDLE) ? 2'b00 : id2onehot(owner_q);
    end

    assign cpu_stall = cpu_req && !cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: round-robin instance checked against a scoreboard of expected
// acks, plus a fixed-priority instance sharing the same stimulus.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic cpu_req, cpu_wr, dma_req, dma_wr;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata, per_rdata;

    logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic        cpu_ack, cpu_stall, dma_ack, mem_rd, mem_wr, per_rd, per_wr;
    logic [1:0]  grant;

    logic [31:0] f_cpu_rdata, f_dma_rdata, f_bus_addr, f_bus_wdata;
    logic        f_cpu_ack, f_cpu_stall, f_dma_ack, f_mem_rd, f_mem_wr, f_per_rd, f_per_wr;
    logic [1:0]  f_grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.CPU_FIXED_PRIO(1'b0), .PER_SEL_BIT(30)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .per_rd(per_rd), .per_wr(per_wr),
        .mem_rdata(mem_rdata), .per_rdata(per_rdata), .grant(grant)
    );

    mem_bus_arbiter #(.CPU_FIXED_PRIO(1'b1), .PER_SEL_BIT(30)) dut_fix (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(f_cpu_rdata), .cpu_ack(f_cpu_ack), .cpu_stall(f_cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(f_dma_rdata), .dma_ack(f_dma_ack),
        .bus_addr(f_bus_addr), .bus_wdata(f_bus_wdata),
        .mem_rd(f_mem_rd), .mem_wr(f_mem_wr), .per_rd(f_per_rd), .per_wr(f_per_wr),
        .mem_rdata(mem_rdata), .per_rdata(per_rdata), .grant(f_grant)
    );

    typedef struct {
        logic        dma;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic dma, input logic rd, input logic [31:0] data);
        exp_t e;
        e.dma  = dma;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_ack();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_who", {30'b0, dma_ack, cpu_ack}, e.dma ? 32'd2 : 32'd1);
            if (e.rd) chk("ack_rdata", e.dma ? dma_rdata : cpu_rdata, e.data);
        end
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!(cpu_ack || dma_ack) && n < max);
        chk("ack_seen", 32'(cpu_ack | dma_ack), 32'd1);
        if (cpu_ack || dma_ack) check_ack();
    endtask

    initial begin
        int  n;
        logic exp_ack;

        reset = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
        mem_rdata = 0; per_rdata = 0;
        repeat (3) cyc();

        // Reset state
        chk("rst_ctl", {25'b0, mem_rd, mem_wr, per_rd, per_wr, grant, cpu_ack}, 32'd0);
        chk("rst_dma_ack", 32'(dma_ack), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        reset = 1'b0;
        cyc();

        // Single CPU store to DataMem
        cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD_BEEF;
        push(1'b0, 1'b0, 32'h0);
        #1 chk("st_stall_req", 32'(cpu_stall), 32'd1);
        cyc();
        cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h0;
        #1;
        chk("st_mem_wr", 32'(mem_wr), 32'd1);
        chk("st_per_wr", 32'(per_wr), 32'd0);
        chk("st_mem_rd", 32'(mem_rd), 32'd0);
        chk("st_bus_addr", bus_addr, 32'h0000_0010);
        chk("st_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        chk("st_grant", 32'(grant), 32'd1);
        chk("st_stall_grant", 32'(cpu_stall), 32'd1);
        cyc();
        check_ack();
        chk("st_mem_wr_ack", 32'(mem_wr), 32'd0);
        chk("st_stall_ack", 32'(cpu_stall), 32'd0);
        chk("st_grant_ack", 32'(grant), 32'd1);
        cpu_req = 0;
        cyc();
        chk("st_grant_idle", 32'(grant), 32'd0);

        // DMA load from Peripheral
        dma_req = 1; dma_wr = 0; dma_addr = 32'h4000_0014;
        per_rdata = 32'h0000_00A5; mem_rdata = 32'h1111_1111;
        push(1'b1, 1'b1, 32'h0000_00A5);
        cyc();
        chk("pl_per_rd", 32'(per_rd), 32'd1);
        chk("pl_mem_rd", 32'(mem_rd), 32'd0);
        chk("pl_grant", 32'(grant), 32'd2);
        cyc();
        check_ack();
        chk("pl_cpu_rdata_kept", cpu_rdata, 32'd0);
        dma_req = 0;
        cyc();

        // Round-robin under continuous requests from both masters
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0020;
        dma_req = 1; dma_wr = 0; dma_addr = 32'h4000_0000;
        mem_rdata = 32'hC0C0_0001; per_rdata = 32'hD0D0_0002;
        push(1'b0, 1'b1, 32'hC0C0_0001);
        push(1'b1, 1'b1, 32'hD0D0_0002);
        push(1'b0, 1'b1, 32'hC0C0_0001);
        push(1'b1, 1'b1, 32'hD0D0_0002);
        for (int i = 0; i < 4; i++) begin
            wait_ack(8, n);
            chk("rr_latency", 32'(n), (i == 0) ? 32'd2 : 32'd3);
        end
        cpu_req = 0; dma_req = 0;
        cyc();

        // Fixed priority: DMA starves while cpu_req stays high
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cpu_req = 1; dma_req = 1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp_ack = (i % 3 == 2);
            chk("fx_cpu_ack", 32'(f_cpu_ack), 32'(exp_ack));
            chk("fx_cpu_stall", 32'(f_cpu_stall), 32'(!exp_ack));
            chk("fx_dma_grant", {30'b0, f_grant[1], f_dma_ack}, 32'd0);
        end
        cpu_req = 0; dma_req = 0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();

        // Reset during GRANT of a DMA write cancels it
        dma_req = 1; dma_wr = 1; dma_addr = 32'h0000_0008; dma_wdata = 32'h0000_0055;
        cyc();
        chk("rg_mem_wr", 32'(mem_wr), 32'd1);
        chk("rg_grant", 32'(grant), 32'd2);
        reset = 1'b1;
        cyc();
        chk("rg_mem_wr_cut", 32'(mem_wr), 32'd0);
        chk("rg_no_ack", 32'(dma_ack), 32'd0);
        chk("rg_bus_addr", bus_addr, 32'd0);
        chk("rg_bus_wdata", bus_wdata, 32'd0);
        chk("rg_grant_rst", 32'(grant), 32'd0);
        reset = 1'b0; dma_req = 0;
        cyc();
        chk("rg_no_ack_after", 32'(dma_ack), 32'd0);

        // CPU drops req during GRANT of a read; a later write keeps cpu_rdata
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h0000_0030; mem_rdata = 32'h1234_5678;
        push(1'b0, 1'b1, 32'h1234_5678);
        cyc();
        cpu_req = 0;
        #1 chk("dr_stall_dropped", 32'(cpu_stall), 32'd0);
        cyc();
        check_ack();
        cyc();
        cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h4000_0000; cpu_wdata = 32'h0000_0099;
        mem_rdata = 32'h0; per_rdata = 32'h0000_0BAD;
        push(1'b0, 1'b0, 32'h0);
        cyc();
        chk("dr_per_wr", 32'(per_wr), 32'd1);
        chk("dr_bus_wdata", bus_wdata, 32'h0000_0099);
        cyc();
        check_ack();
        chk("dr_rdata_kept", cpu_rdata, 32'h1234_5678);
        cpu_req = 0;
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
